// File: rtl/io_clk_pkg.sv
// Shared sizing and types for the IO divided-clock bank.
// Eight channels, each with a 16-bit half-period divisor.
package io_clk_pkg;
    localparam int NUM_IO_CLKS      = 8;
    localparam int IO_CLK_DIV_WIDTH = 16;

    typedef logic [IO_CLK_DIV_WIDTH-1:0]     io_clk_div_t;
    typedef logic [$clog2(NUM_IO_CLKS)-1:0]  io_clk_idx_t;
endpackage

// File: rtl/io_clk_div_channel.sv
// One divided clock: half-period counter, toggle flop, staged divisor.
// A staged divisor is applied only while idle or at the falling toggle.
module io_clk_div_channel
    import io_clk_pkg::*;
#(
    parameter int                   DIV_WIDTH = IO_CLK_DIV_WIDTH,
    parameter logic [DIV_WIDTH-1:0] RESET_DIV = '0
) (
    input  logic                 sys_clk,
    input  logic                 async_rst,
    input  logic                 clk_en,
    input  logic                 wr_en,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic                 clk_out,
    output logic                 rise,
    output logic                 pending
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] staged_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 idle;
    logic                 at_end;
    logic                 apply;

    assign idle   = (div_q == '0);
    assign at_end = (cnt_q == div_q - 1'b1);
    // Falling toggle (or idle) is the only safe point to swap divisors.
    assign apply  = pending && (idle || (clk_out && at_end));

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            div_q    <= RESET_DIV;
            staged_q <= RESET_DIV;
            cnt_q    <= '0;
            clk_out  <= 1'b0;
            rise     <= 1'b0;
            pending  <= 1'b0;
        end else if (clk_en) begin
            if (wr_en && !pending) begin
                staged_q <= wr_div;
                pending  <= 1'b1;
            end
            if (apply) begin
                div_q   <= staged_q;
                cnt_q   <= '0;
                clk_out <= 1'b0;
                rise    <= 1'b0;
                pending <= 1'b0;
            end else if (idle) begin
                cnt_q   <= '0;
                clk_out <= 1'b0;
                rise    <= 1'b0;
            end else if (at_end) begin
                cnt_q   <= '0;
                clk_out <= ~clk_out;
                rise    <= ~clk_out;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                rise    <= 1'b0;
            end
        end else begin
            rise <= 1'b0;
        end
    end

endmodule

// File: rtl/io_clk_divider_bank.sv
// Bank of programmable divided IO clocks with a valid/ready config port.
// Top level only decodes the target channel and muxes back its ready.
module io_clk_divider_bank
    import io_clk_pkg::*;
#(
    parameter int                   NUM_CLKS  = NUM_IO_CLKS,
    parameter int                   DIV_WIDTH = IO_CLK_DIV_WIDTH,
    parameter logic [DIV_WIDTH-1:0] RESET_DIV = '0
) (
    input  logic                        sys_clk,
    input  logic                        async_rst,
    input  logic                        clk_en,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(NUM_CLKS)-1:0] cfg_index,
    input  logic [DIV_WIDTH-1:0]        cfg_divisor,
    output logic [NUM_CLKS-1:0]         divided_clks,
    output logic [NUM_CLKS-1:0]         divided_rise,
    output logic [NUM_CLKS-1:0]         update_pending
);

    localparam int IDX_W = $clog2(NUM_CLKS);

    logic                index_ok;
    logic                take;
    logic [NUM_CLKS-1:0] wr_en;

    // Out-of-range targets always look ready so the write is simply dropped.
    assign index_ok  = (int'(cfg_index) < NUM_CLKS);
    assign cfg_ready = index_ok ? ~update_pending[cfg_index] : 1'b1;
    assign take      = cfg_valid && cfg_ready && clk_en && index_ok;

    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
        assign wr_en[i] = take && (cfg_index == IDX_W'(i));

        io_clk_div_channel #(
            .DIV_WIDTH (DIV_WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .sys_clk   (sys_clk),
            .async_rst (async_rst),
            .clk_en    (clk_en),
            .wr_en     (wr_en[i]),
            .wr_div    (cfg_divisor),
            .clk_out   (divided_clks[i]),
            .rise      (divided_rise[i]),
            .pending   (update_pending[i])
        );
    end

endmodule

// File: tb/tb_io_clk_divider_bank.sv
// Randomized and directed bench for io_clk_divider_bank with an
// arithmetic model: output phase is derived from cycles since last apply.
module tb_io_clk_divider_bank;

    logic        sys_clk = 1'b0;
    logic        async_rst;
    logic        clk_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_index;
    logic [15:0] cfg_divisor;
    logic [7:0]  divided_clks;
    logic [7:0]  divided_rise;
    logic [7:0]  update_pending;

    io_clk_divider_bank dut (
        .sys_clk        (sys_clk),
        .async_rst      (async_rst),
        .clk_en         (clk_en),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_index      (cfg_index),
        .cfg_divisor    (cfg_divisor),
        .divided_clks   (divided_clks),
        .divided_rise   (divided_rise),
        .update_pending (update_pending)
    );

    always #10 sys_clk = ~sys_clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: n = enabled edges since the divisor was applied.
    // Output is high during odd multiples of D; apply is allowed only
    // when the next edge ends a full 2*D period (i.e. the falling toggle).
    int unsigned      m_d[8];
    int unsigned      m_stg[8];
    longint unsigned  m_n[8];
    bit               m_pend[8];
    bit               m_rise[8];

    function automatic bit m_o(input int i);
        if (m_d[i] == 0) return 1'b0;
        return ((m_n[i] / m_d[i]) % 2) == 1;
    endfunction

    always @(posedge sys_clk or posedge async_rst) begin
        bit acc;
        if (async_rst) begin
            for (int i = 0; i < 8; i++) begin
                m_d[i] = 0; m_stg[i] = 0; m_n[i] = 0;
                m_pend[i] = 0; m_rise[i] = 0;
            end
        end else if (clk_en) begin
            acc = cfg_valid && !m_pend[cfg_index];
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && (m_d[i] == 0 ||
                    (m_n[i] + 1) % (2 * longint'(m_d[i])) == 0)) begin
                    m_d[i] = m_stg[i];
                    m_n[i] = 0;
                    m_pend[i] = 0;
                    m_rise[i] = 0;
                end else if (m_d[i] == 0) begin
                    m_rise[i] = 0;
                end else begin
                    m_n[i]++;
                    m_rise[i] = m_o(i) && (m_n[i] % m_d[i] == 0);
                end
            end
            if (acc) begin
                m_stg[cfg_index] = cfg_divisor;
                m_pend[cfg_index] = 1;
            end
        end else begin
            for (int i = 0; i < 8; i++) m_rise[i] = 0;
        end
    end

    always @(negedge sys_clk) begin
        logic [7:0] eo, er, ep;
        for (int i = 0; i < 8; i++) begin
            eo[i] = m_o(i);
            er[i] = m_rise[i];
            ep[i] = m_pend[i];
        end
        chk("clks", 64'(divided_clks), 64'(eo));
        chk("rise", 64'(divided_rise), 64'(er));
        chk("pending", 64'(update_pending), 64'(ep));
        chk("ready", 64'(cfg_ready), 64'(!m_pend[cfg_index]));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic wr(input int idx, input int div);
        int k = 0;
        cfg_index   = 3'(idx);
        cfg_divisor = 16'(div);
        cfg_valid   = 1'b1;
        #1;
        while (!cfg_ready && k < 200) begin
            cyc(1);
            k++;
        end
        chk("wr_wait_bound", 64'(k < 200), 64'd1);
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h, l, r, run, maxrun;
        logic prev;
        logic [7:0] snap;

        async_rst = 1'b0; clk_en = 1'b1; cfg_valid = 1'b0;
        cfg_index = '0; cfg_divisor = '0;
        #1 async_rst = 1'b1;
        cyc(2);
        async_rst = 1'b0;
        cyc(2);

        // Reset state and idle ready on every index
        chk("rst_clks", 64'(divided_clks), 64'd0);
        chk("rst_pend", 64'(update_pending), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cfg_index = 3'(i);
            #1;
            chk("rst_ready", 64'(cfg_ready), 64'd1);
        end
        cyc(1);

        // Enable idx2 at div 3
        wr(2, 3);
        chk("en_pend_hi", 64'(update_pending[2]), 64'd1);
        cyc(1);
        chk("en_pend_lo", 64'(update_pending[2]), 64'd0);
        n = 0;
        while (!divided_clks[2] && n < 20) begin cyc(1); n++; end
        chk("first_rise_delay", 64'(n), 64'd3);
        chk("first_rise_pulse", 64'(divided_rise[2]), 64'd1);
        h = 0;
        while (divided_clks[2] && h < 20) begin cyc(1); h++; end
        chk("high_len", 64'(h), 64'd3);
        l = 0;
        while (!divided_clks[2] && l < 20) begin cyc(1); l++; end
        chk("low_len", 64'(l), 64'd3);
        r = 0;
        repeat (6) begin r += int'(divided_rise[2]); cyc(1); end
        chk("rise_per_period", 64'(r), 64'd1);

        // Change to div 1 in the middle of a high phase
        n = 0;
        while (!divided_clks[2] && n < 20) begin cyc(1); n++; end
        cyc(1);
        wr(2, 1);
        maxrun = 0; run = 0; prev = divided_clks[2];
        repeat (30) begin
            cyc(1);
            if (divided_clks[2] == prev) run++;
            else begin
                if (run + 1 > maxrun) maxrun = run + 1;
                run = 0;
            end
            prev = divided_clks[2];
        end
        chk("max_phase_le3", 64'(maxrun <= 3 && maxrun >= 1), 64'd1);
        repeat (4) begin
            cyc(1);
            chk("div1_toggle", 64'(divided_clks[2] != prev), 64'd1);
            prev = divided_clks[2];
        end

        // Stall on pending idx2, idx5 accepted meanwhile
        wr(2, 5);
        n = 0;
        while (!divided_rise[2] && n < 40) begin cyc(1); n++; end
        wr(2, 2);
        cfg_index = 3'd2; cfg_divisor = 16'd3; cfg_valid = 1'b1;
        #1;
        chk("stall_ready", 64'(cfg_ready), 64'd0);
        cyc(1);
        chk("stall_pend", 64'(update_pending[2]), 64'd1);
        cfg_index = 3'd5; cfg_divisor = 16'd4;
        #1;
        chk("idx5_ready", 64'(cfg_ready), 64'd1);
        cyc(1);
        chk("idx5_pend", 64'(update_pending[5]), 64'd1);
        cfg_valid = 1'b0;
        wr(2, 3);

        // Freeze with clk_en low
        cyc(4);
        snap = divided_clks;
        clk_en = 1'b0;
        n = 0;
        repeat (10) begin
            cyc(1);
            n += int'(divided_clks == snap && divided_rise == 8'd0);
        end
        chk("freeze_hold", 64'(n), 64'd10);
        clk_en = 1'b1;
        cyc(20);

        // Async reset between edges with a write pending
        wr(2, 7);
        chk("pre_rst_pend", 64'(update_pending[2]), 64'd1);
        #2 async_rst = 1'b1;
        #1;
        chk("rst_now_clks", 64'(divided_clks), 64'd0);
        chk("rst_now_pend", 64'(update_pending), 64'd0);
        cyc(2);
        async_rst = 1'b0;
        cyc(5);
        chk("post_rst_clks", 64'(divided_clks), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cfg_index = 3'(i);
            #1;
            chk("post_rst_ready", 64'(cfg_ready), 64'd1);
        end
        cyc(1);

        // Randomized traffic
        repeat (600) begin
            clk_en      = ($urandom_range(0, 9) != 0);
            cfg_valid   = ($urandom_range(0, 2) == 0);
            cfg_index   = 3'($urandom_range(0, 7));
            cfg_divisor = ($urandom_range(0, 4) == 0) ? 16'd0
                        : 16'($urandom_range(1, 6));
            cyc(1);
        end
        clk_en = 1'b1; cfg_valid = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
